// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int                 INSTR_W    = 32;
  localparam logic [INSTR_W-1:0] ZERO_INSTR = '0;
  localparam logic [31:0]        PC_STEP    = 32'd4;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, and load beats consume.
// A consume with no new load empties the slot.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_consume,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, fetch FSM, memory read port and handshake counter.
// Fetched words land in if_id_reg one cycle after the read.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter int          COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  output logic               imem_re,
  output logic               imem_we,
  output logic [31:0]        imem_din,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic               halted,
  output logic               fetch_err,
  output logic [COUNT_W-1:0] fetch_count
);
  state_e             r_state, w_state_nxt;
  logic [31:0]        r_pc, w_pc_nxt;
  logic               r_err, w_err_set;
  logic [COUNT_W-1:0] r_count;

  logic w_adv, w_hs, w_oor, w_redir, w_redir_mis, w_redir_oor;
  logic w_fetch, w_zero, w_load;

  assign w_adv       = !out_valid || out_ready;
  assign w_hs        = out_valid && out_ready;
  assign w_oor       = {2'b00, r_pc[31:2]} >= 32'(IMEM_DEPTH);
  assign w_redir     = redirect_valid && (r_state != IDLE);
  assign w_redir_mis = redirect_pc[1:0] != 2'b00;
  assign w_redir_oor = {2'b00, redirect_pc[31:2]} >= 32'(IMEM_DEPTH);
  // An out-of-range PC never reaches the memory port.
  assign w_fetch     = (r_state == RUN) && w_adv && !redirect_valid && !w_oor;
  assign w_zero      = imem_rdata == ZERO_INSTR;
  assign w_load      = w_fetch && !w_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = RUN;
      RUN, HALT: begin
        if (w_redir) begin
          if (w_redir_mis) begin
            w_state_nxt = HALT;
            w_err_set   = 1'b1;
          end else begin
            w_pc_nxt = redirect_pc;
            if (w_redir_oor) begin
              w_state_nxt = HALT;
              w_err_set   = 1'b1;
            end else begin
              w_state_nxt = RUN;
            end
          end
        end else if (r_state == RUN) begin
          if (w_oor) begin
            w_state_nxt = HALT;
            w_err_set   = 1'b1;
          end else if (w_fetch) begin
            if (w_zero) w_state_nxt = HALT;
            else        w_pc_nxt    = r_pc + PC_STEP;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_hs)      r_count <= r_count + COUNT_W'(1);
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_flush   (w_redir),
    .i_consume (w_hs),
    .i_instr   (imem_rdata),
    .i_pc      (r_pc),
    .o_valid   (out_valid),
    .o_instr   (out_instr),
    .o_pc      (out_pc)
  );

  assign imem_addr   = {2'b00, r_pc[31:2]};
  assign imem_re     = w_fetch;
  assign imem_we     = 1'b0;
  assign imem_din    = '0;
  assign halted      = r_state == HALT;
  assign fetch_err   = r_err;
  assign fetch_count = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vectors plus a random
// stream checked against a program-order scoreboard.
module tb_instr_fetch_unit;
  logic        clk, rst_n;
  logic [31:0] imem_addr, imem_din, imem_rdata, redirect_pc, out_instr, out_pc, fetch_count;
  logic        imem_re, imem_we, redirect_valid, out_valid, out_ready, halted, fetch_err;

  logic [31:0] mem [256];
  int          n_chk, n_err;
  logic        bad_re;

  localparam logic [31:0] W0 = 32'h00302083, W1 = 32'h00008533, W2 = 32'h00A024A3;

  assign imem_rdata = (imem_addr < 32'd256) ? mem[imem_addr[7:0]] : 32'h0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_re(imem_re), .imem_we(imem_we),
    .imem_din(imem_din), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .halted(halted), .fetch_err(fetch_err),
    .fetch_count(fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (imem_re && imem_addr == 32'h100) bad_re <= 1'b1;

  typedef struct {
    logic        ready;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        h;
    logic [31:0] cnt;
    logic        re;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = W0; mem[1] = W1; mem[2] = W2;
  endtask

  // Ends on a negedge with reset released; the next posedge leaves IDLE.
  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_halt",  {31'b0, halted}, 32'h0);
    chk("rst_err",   {31'b0, fetch_err}, 32'h0);
    chk("rst_re",    {31'b0, imem_re}, 32'h0);
  endtask

  initial begin
    logic [31:0] m_pc, m_cnt, tgt;
    logic        m_err;
    n_chk = 0; n_err = 0; bad_re = 1'b0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    // Straight-line program ending on a zero word.
    tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 32'h0, W0,    1'b0, 32'd0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h4, W1,    1'b0, 32'd1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h8, W2,    1'b0, 32'd2, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'd3, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'd3, 1'b0};
    load_prog();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = tbl[i].ready;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].instr);
      end
      chk($sformatf("tbl%0d_halt", i), {31'b0, halted}, {31'b0, tbl[i].h});
      chk($sformatf("tbl%0d_cnt", i), fetch_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_re", i), {31'b0, imem_re}, {31'b0, tbl[i].re});
    end
    chk("tbl_err", {31'b0, fetch_err}, 32'h0);

    // Backpressure: first word held three cycles, then the stream resumes.
    do_reset();
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_pc", out_pc, 32'h0);
      chk("bp_instr", out_instr, W0);
      chk("bp_re", {31'b0, imem_re}, 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_pc4", out_pc, 32'h4); chk("bp_i4", out_instr, W1); chk("bp_c1", fetch_count, 32'd1);
    @(negedge clk); #1;
    chk("bp_pc8", out_pc, 32'h8); chk("bp_i8", out_instr, W2); chk("bp_c2", fetch_count, 32'd2);
    @(negedge clk); #1;
    chk("bp_end_v", {31'b0, out_valid}, 32'h0); chk("bp_end_h", {31'b0, halted}, 32'h1);
    chk("bp_end_c", fetch_count, 32'd3);

    // Redirect while stalled, then misaligned redirect, then recovery.
    do_reset();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1; chk("rd_pre_pc", out_pc, 32'h4);
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
    #1; chk("rd_re0", {31'b0, imem_re}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rd_flush", {31'b0, out_valid}, 32'h0); chk("rd_cnt", fetch_count, 32'd1);
    chk("rd_addr", imem_addr, 32'h2);
    @(negedge clk); #1;
    chk("rd_v", {31'b0, out_valid}, 32'h1); chk("rd_pc", out_pc, 32'h8); chk("rd_i", out_instr, W2);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("mis_halt", {31'b0, halted}, 32'h1); chk("mis_err", {31'b0, fetch_err}, 32'h1);
    chk("mis_v", {31'b0, out_valid}, 32'h0); chk("mis_cnt", fetch_count, 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("mis_re", {31'b0, imem_re}, 32'h0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("res_halt", {31'b0, halted}, 32'h0); chk("res_re", {31'b0, imem_re}, 32'h1);
    chk("res_addr", imem_addr, 32'h0);
    @(negedge clk); #1;
    chk("res_pc", out_pc, 32'h0); chk("res_i", out_instr, W0);

    // Redirect beyond the end of memory.
    do_reset();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bad_re = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("oor_halt", {31'b0, halted}, 32'h1); chk("oor_err", {31'b0, fetch_err}, 32'h1);
    chk("oor_v", {31'b0, out_valid}, 32'h0);
    repeat (4) @(negedge clk);
    chk("oor_nore", {31'b0, bad_re}, 32'h0); chk("oor_err2", {31'b0, fetch_err}, 32'h1);

    // Asynchronous reset between edges mid-stream.
    do_reset();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1; chk("ar_pre_v", {31'b0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_v", {31'b0, out_valid}, 32'h0); chk("ar_cnt", fetch_count, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ar_idle_v", {31'b0, out_valid}, 32'h0); chk("ar_re", {31'b0, imem_re}, 32'h1);
    chk("ar_addr", imem_addr, 32'h0);
    @(negedge clk); #1;
    chk("ar_pc", out_pc, 32'h0); chk("ar_i", out_instr, W0); chk("ar_c0", fetch_count, 32'h0);

    // Random stream: every accepted word must follow program order from the last redirect.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
    mem[255] = 32'h0;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    m_pc = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      chk("rnd_cnt", fetch_count, m_cnt);
      chk("rnd_err", {31'b0, fetch_err}, {31'b0, m_err});
      out_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 9) == 0;
      tgt = {22'h0, 8'($urandom_range(0, 250)), 2'b00};
      if ($urandom_range(0, 40) == 0) tgt[1:0] = 2'b10;
      redirect_pc = tgt;
      if (out_valid && out_ready) begin
        chk("rnd_pc", out_pc, m_pc);
        chk("rnd_instr", out_instr, mem[m_pc[9:2]]);
        m_cnt = m_cnt + 1;
        m_pc  = m_pc + 4;
      end
      if (redirect_valid) begin
        if (tgt[1:0] != 2'b00) m_err = 1'b1;
        else                   m_pc  = tgt;
      end
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
